idecode: RTL and testbench
==========================

IDECODE -- requirements
Module: idecode

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port instruction, input, 16, fetched instruction from the fetch stage.
REQ-004 SHALL have port pcIn, input, 16, incremented PC from the fetch stage.
REQ-005 SHALL have port wbEn, input, 1, register-file write enable from write-back.
REQ-006 SHALL have port wbReg, input, 3, write-back destination register.
REQ-007 SHALL have port wbData, input, 16, write-back data.
REQ-008 SHALL have port flush, input, 1, squash the current decode slot (taken branch).
REQ-009 SHALL have port rsData, output, 16, registered Rs operand.
REQ-010 SHALL have port rtData, output, 16, registered Rt operand.
REQ-011 SHALL have port immExt, output, 16, registered sign-extended immediate.
REQ-012 SHALL have port destReg, output, 3, registered destination register.
REQ-013 SHALL have port regWrite, output, 1, registered write flag.
REQ-014 SHALL have port pcOut, output, 16, registered copy of pcIn.
REQ-015 SHALL have port instrOut, output, 16, registered instruction.
REQ-016 SHALL have port stall, output, 1, combinational hold request to fetch.
REQ-017 SHALL have port halt, output, 1, registered sticky halt.

Function
REQ-018 SHALL decode opcode=[15:11], Rs=[10:8], Rt=[7:5].
REQ-019 SHALL classify opcodes: 00000 HALT; 00001 NOP; 11010/11011 R-type (reads Rs and Rt, writes [4:2]); 01xxx I-type (reads Rs, writes [7:5], imm = sext [4:0]); 10xxx store (reads Rs and Rt, imm = sext [4:0], no write); 11000 LBI (writes Rs, imm = sext [7:0]); 001xx branch/jump (reads Rs, imm = sext [7:0], no write); all others NOP.
REQ-020 SHALL hold an 8x16 register file, written on the rising edge when wbEn=1.
REQ-021 SHALL read operands combinationally, bypassing wbData when wbEn=1 and wbReg equals the read register.
REQ-022 SHALL keep a 2-bit pending counter per register (scoreboard).
REQ-023 SHALL assert stall when any register read by the current class has a non-zero counter, and flush=0.
REQ-024 SHALL, on an issuing edge (stall=0, flush=0, halt=0, instruction writes d), set counter[d] to 2; all other non-zero counters decrement by 1; set wins over decrement for the same register.
REQ-025 SHALL, on an issuing edge, register decoded values into all outputs (latency 1 cycle).
REQ-026 SHALL, on a non-issuing edge (stall, flush or halt), load a bubble: instrOut=0x0800, regWrite=0, destReg=0, rsData=rtData=immExt=0, pcOut=pcIn.
REQ-027 SHALL set halt on the edge that issues a HALT; halt stays 1 until rst, and all later slots are bubbles.
REQ-028 SHALL give flush priority over stall; flushed instructions never update the scoreboard.
REQ-029 SHALL allow wbEn writes in every cycle, including stall, flush and halt.

Reset
REQ-030 SHALL, while rst=1, clear all registers and counters to 0, set halt=0, and set outputs to the bubble of REQ-026 with pcOut=0.
REQ-031 SHALL give rst precedence over a coincident clock edge; reset mid-stall leaves stall=0 after release.

Structure
REQ-032 SHALL take opcode constants, the class enumeration and the NOP value 0x0800 from the shared package isa_pkg.
REQ-033 SHALL instantiate exactly one sub-module, regfile8x16 (two read ports, one write port, bypass).

Verification
REQ-034 After reset, instruction=0x0800 -> stall=0, regWrite=0, instrOut=0x0800, halt=0.
REQ-035 wbEn=1, wbReg=3, wbData=0x1234, with an R-type instruction reading R3 in the same cycle -> rsData=0x1234 next cycle.
REQ-036 I-type writing R2, then an R-type reading R2 -> stall=1 for exactly 2 cycles, then the instruction issues.
REQ-037 flush=1 while stall=1 -> stall=0, bubble issued, scoreboard unchanged.
REQ-038 HALT followed by an I-type writing R1 -> halt=1 from the next cycle, and regWrite never asserts for R1.
REQ-039 rst pulsed mid-stall with counter[5]=2 -> all counters 0, halt=0, stall=0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, instruction classes,
// the canonical NOP encoding and the field decoder used by idecode.
package isa_pkg;

   localparam logic [15:0] NOP_INSTR = 16'h0800;

   localparam logic [4:0] OP_HALT   = 5'b00000;
   localparam logic [4:0] OP_NOP    = 5'b00001;
   localparam logic [4:0] OP_RTYPE0 = 5'b11010;
   localparam logic [4:0] OP_RTYPE1 = 5'b11011;
   localparam logic [4:0] OP_LBI    = 5'b11000;

   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_HALT,
      CLS_RTYPE,
      CLS_ITYPE,
      CLS_STORE,
      CLS_LBI,
      CLS_BRANCH
   } iclass_t;

   typedef struct packed {
      iclass_t     cls;
      logic        reads_rs;
      logic        reads_rt;
      logic        writes;
      logic [2:0]  dest;
      logic [15:0] imm;
   } decode_t;

   function automatic logic [15:0] sext5(input logic [4:0] v);
      return {{11{v[4]}}, v};
   endfunction

   function automatic logic [15:0] sext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

   // dest is left at zero for classes that do not write, so it can be registered as-is
   function automatic decode_t decode_instr(input logic [15:0] instr);
      decode_t d;
      d.cls      = CLS_NOP;
      d.reads_rs = 1'b0;
      d.reads_rt = 1'b0;
      d.writes   = 1'b0;
      d.dest     = 3'd0;
      d.imm      = 16'h0000;
      casez (instr[15:11])
         OP_HALT: d.cls = CLS_HALT;
         OP_NOP:  d.cls = CLS_NOP;
         OP_RTYPE0, OP_RTYPE1: begin
            d.cls      = CLS_RTYPE;
            d.reads_rs = 1'b1;
            d.reads_rt = 1'b1;
            d.writes   = 1'b1;
            d.dest     = instr[4:2];
         end
         5'b01???: begin
            d.cls      = CLS_ITYPE;
            d.reads_rs = 1'b1;
            d.writes   = 1'b1;
            d.dest     = instr[7:5];
            d.imm      = sext5(instr[4:0]);
         end
         5'b10???: begin
            d.cls      = CLS_STORE;
            d.reads_rs = 1'b1;
            d.reads_rt = 1'b1;
            d.imm      = sext5(instr[4:0]);
         end
         OP_LBI: begin
            d.cls    = CLS_LBI;
            d.writes = 1'b1;
            d.dest   = instr[10:8];
            d.imm    = sext8(instr[7:0]);
         end
         5'b001??: begin
            d.cls      = CLS_BRANCH;
            d.reads_rs = 1'b1;
            d.imm      = sext8(instr[7:0]);
         end
         default: d.cls = CLS_NOP;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/regfile8x16.sv
// 8 x 16-bit register file: two combinational read ports and one write port,
// with same-cycle write data forwarded to the readers.
module regfile8x16
   import isa_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  raddr_a,
   input  logic [2:0]  raddr_b,
   output logic [15:0] rdata_a,
   output logic [15:0] rdata_b,
   input  logic        wen,
   input  logic [2:0]  waddr,
   input  logic [15:0] wdata
);

   logic [15:0] mem_r [8];

   // storage write, cleared on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            mem_r[i] <= 16'h0000;
         end
      end else if (wen) begin
         mem_r[waddr] <= wdata;
      end
   end

   // read port A with write-through bypass
   always_comb begin
      rdata_a = 16'h0000;
      if (wen && (waddr == raddr_a)) begin
         rdata_a = wdata;
      end else begin
         rdata_a = mem_r[raddr_a];
      end
   end

   // read port B with write-through bypass
   always_comb begin
      rdata_b = 16'h0000;
      if (wen && (waddr == raddr_b)) begin
         rdata_b = wdata;
      end else begin
         rdata_b = mem_r[raddr_b];
      end
   end

endmodule

// File: rtl/idecode.sv
// Decode stage: classifies the fetched instruction, reads operands, tracks
// in-flight destinations with 2-bit counters and registers the decoded slot.
module idecode
   import isa_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instruction,
   input  logic [15:0] pcIn,
   input  logic        wbEn,
   input  logic [2:0]  wbReg,
   input  logic [15:0] wbData,
   input  logic        flush,
   output logic [15:0] rsData,
   output logic [15:0] rtData,
   output logic [15:0] immExt,
   output logic [2:0]  destReg,
   output logic        regWrite,
   output logic [15:0] pcOut,
   output logic [15:0] instrOut,
   output logic        stall,
   output logic        halt
);

   decode_t     dec_s;
   logic [2:0]  rs_s;
   logic [2:0]  rt_s;
   logic [15:0] rs_val_s;
   logic [15:0] rt_val_s;
   logic        busy_s;
   logic        stall_s;
   logic        issue_s;
   logic [1:0]  cnt_r [8];
   logic        halt_r;

   assign dec_s = decode_instr(instruction);
   assign rs_s  = instruction[10:8];
   assign rt_s  = instruction[7:5];

   regfile8x16 u_regfile (
      .clk     (clk),
      .rst     (rst),
      .raddr_a (rs_s),
      .raddr_b (rt_s),
      .rdata_a (rs_val_s),
      .rdata_b (rt_val_s),
      .wen     (wbEn),
      .waddr   (wbReg),
      .wdata   (wbData)
   );

   // hazard check: flush squashes the slot, so it never needs to hold fetch
   always_comb begin
      busy_s  = (dec_s.reads_rs && (cnt_r[rs_s] != 2'd0)) ||
                (dec_s.reads_rt && (cnt_r[rt_s] != 2'd0));
      stall_s = busy_s && !flush;
      issue_s = !stall_s && !flush && !halt_r;
   end

   assign stall = stall_s;
   assign halt  = halt_r;

   // pending-write counters: an issuing writer reloads its entry, everything else ages
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            cnt_r[i] <= 2'd0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (issue_s && dec_s.writes && (dec_s.dest == 3'(i))) begin
               cnt_r[i] <= 2'd2;
            end else if (cnt_r[i] != 2'd0) begin
               cnt_r[i] <= cnt_r[i] - 2'd1;
            end else begin
               cnt_r[i] <= 2'd0;
            end
         end
      end
   end

   // sticky halt
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halt_r <= 1'b0;
      end else if (issue_s && (dec_s.cls == CLS_HALT)) begin
         halt_r <= 1'b1;
      end
   end

   // decode slot register: issued values or a bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsData   <= 16'h0000;
         rtData   <= 16'h0000;
         immExt   <= 16'h0000;
         destReg  <= 3'd0;
         regWrite <= 1'b0;
         pcOut    <= 16'h0000;
         instrOut <= NOP_INSTR;
      end else if (issue_s) begin
         rsData   <= dec_s.reads_rs ? rs_val_s : 16'h0000;
         rtData   <= dec_s.reads_rt ? rt_val_s : 16'h0000;
         immExt   <= dec_s.imm;
         destReg  <= dec_s.dest;
         regWrite <= dec_s.writes;
         pcOut    <= pcIn;
         instrOut <= instruction;
      end else begin
         rsData   <= 16'h0000;
         rtData   <= 16'h0000;
         immExt   <= 16'h0000;
         destReg  <= 3'd0;
         regWrite <= 1'b0;
         pcOut    <= pcIn;
         instrOut <= NOP_INSTR;
      end
   end

endmodule

// File: tb/tb_idecode.sv
// Self-checking bench for idecode: a reference model predicts each slot,
// expectations are queued at drive time and compared after the clock edge.
module tb_idecode;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] instruction = 16'h0800;
   logic [15:0] pcIn = 16'h0000;
   logic        wbEn = 1'b0;
   logic [2:0]  wbReg = 3'd0;
   logic [15:0] wbData = 16'h0000;
   logic        flush = 1'b0;
   logic [15:0] rsData, rtData, immExt, pcOut, instrOut;
   logic [2:0]  destReg;
   logic        regWrite, stall, halt;

   idecode dut (
      .clk(clk), .rst(rst), .instruction(instruction), .pcIn(pcIn),
      .wbEn(wbEn), .wbReg(wbReg), .wbData(wbData), .flush(flush),
      .rsData(rsData), .rtData(rtData), .immExt(immExt), .destReg(destReg),
      .regWrite(regWrite), .pcOut(pcOut), .instrOut(instrOut),
      .stall(stall), .halt(halt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] rs;
      logic [15:0] rt;
      logic [15:0] imm;
      logic [15:0] pc;
      logic [15:0] instr;
      logic [2:0]  dest;
      logic        rw;
      logic        hlt;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] m_rf [8];
   logic [1:0]  m_cnt [8];
   logic        m_halt;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic void m_dec(input logic [15:0] ins, output logic rrs, output logic rrt,
                                 output logic wr, output logic ish, output logic [2:0] d,
                                 output logic [15:0] im);
      logic [4:0] op;
      op = ins[15:11];
      rrs = 1'b0; rrt = 1'b0; wr = 1'b0; ish = 1'b0; d = 3'd0; im = 16'h0000;
      if (op == 5'b00000) ish = 1'b1;
      else if (op == 5'b11010 || op == 5'b11011) begin
         rrs = 1'b1; rrt = 1'b1; wr = 1'b1; d = ins[4:2];
      end else if (op[4:3] == 2'b01) begin
         rrs = 1'b1; wr = 1'b1; d = ins[7:5]; im = {{11{ins[4]}}, ins[4:0]};
      end else if (op[4:3] == 2'b10) begin
         rrs = 1'b1; rrt = 1'b1; im = {{11{ins[4]}}, ins[4:0]};
      end else if (op == 5'b11000) begin
         wr = 1'b1; d = ins[10:8]; im = {{8{ins[7]}}, ins[7:0]};
      end else if (op[4:2] == 3'b001) begin
         rrs = 1'b1; im = {{8{ins[7]}}, ins[7:0]};
      end
   endfunction

   function automatic void m_clear();
      for (int i = 0; i < 8; i++) begin
         m_rf[i] = 16'h0000;
         m_cnt[i] = 2'd0;
      end
      m_halt = 1'b0;
   endfunction

   // one decode slot; st_obs is the stall the DUT showed during the slot
   task automatic run_cycle(input logic [15:0] ins, input logic [15:0] pc, input logic f,
                            input logic we, input logic [2:0] wr_reg, input logic [15:0] wd,
                            output logic st_obs);
      exp_t e;
      logic rrs, rrt, wr, ish, st, iss;
      logic [2:0] d;
      logic [15:0] im, vrs, vrt;
      @(negedge clk);
      instruction = ins; pcIn = pc; flush = f; wbEn = we; wbReg = wr_reg; wbData = wd;
      #1;
      m_dec(ins, rrs, rrt, wr, ish, d, im);
      st = ((rrs && m_cnt[ins[10:8]] != 2'd0) || (rrt && m_cnt[ins[7:5]] != 2'd0)) && !f;
      st_obs = stall;
      check_val("stall", {31'd0, stall}, {31'd0, st});
      iss = !st && !f && !m_halt;
      vrs = (we && wr_reg == ins[10:8]) ? wd : m_rf[ins[10:8]];
      vrt = (we && wr_reg == ins[7:5]) ? wd : m_rf[ins[7:5]];
      e.pc = pc;
      if (iss) begin
         e.rs = rrs ? vrs : 16'h0000; e.rt = rrt ? vrt : 16'h0000; e.imm = im;
         e.instr = ins; e.dest = wr ? d : 3'd0; e.rw = wr;
      end else begin
         e.rs = 16'h0000; e.rt = 16'h0000; e.imm = 16'h0000;
         e.instr = 16'h0800; e.dest = 3'd0; e.rw = 1'b0;
      end
      e.hlt = m_halt || (iss && ish);
      sbq.push_back(e);
      for (int i = 0; i < 8; i++) begin
         if (iss && wr && d == 3'(i)) m_cnt[i] = 2'd2;
         else if (m_cnt[i] != 2'd0) m_cnt[i] = m_cnt[i] - 2'd1;
      end
      if (we) m_rf[wr_reg] = wd;
      m_halt = e.hlt;
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check_val("rsData", {16'd0, rsData}, {16'd0, e.rs});
      check_val("rtData", {16'd0, rtData}, {16'd0, e.rt});
      check_val("immExt", {16'd0, immExt}, {16'd0, e.imm});
      check_val("pcOut", {16'd0, pcOut}, {16'd0, e.pc});
      check_val("instrOut", {16'd0, instrOut}, {16'd0, e.instr});
      check_val("destReg", {29'd0, destReg}, {29'd0, e.dest});
      check_val("regWrite", {31'd0, regWrite}, {31'd0, e.rw});
      check_val("halt", {31'd0, halt}, {31'd0, e.hlt});
   endtask

   // hold an instruction until the DUT lets it through (bounded)
   task automatic issue_instr(input logic [15:0] ins, input logic [15:0] pc, output int nstall);
      logic st;
      nstall = 0;
      for (int k = 0; k < 6; k++) begin
         run_cycle(ins, pc, 1'b0, 1'b0, 3'd0, 16'h0000, st);
         if (!st) break;
         nstall++;
      end
   endtask

   task automatic check_bubble_reset(input string tag);
      check_val({tag, "_instrOut"}, {16'd0, instrOut}, 32'h0000_0800);
      check_val({tag, "_pcOut"}, {16'd0, pcOut}, 32'h0);
      check_val({tag, "_regWrite"}, {31'd0, regWrite}, 32'h0);
      check_val({tag, "_destReg"}, {29'd0, destReg}, 32'h0);
      check_val({tag, "_ops"}, {rsData | rtData, immExt}, 32'h0);
      check_val({tag, "_halt"}, {31'd0, halt}, 32'h0);
      check_val({tag, "_stall"}, {31'd0, stall}, 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; instruction = 16'h0800; pcIn = 16'h1111; flush = 1'b0; wbEn = 1'b0;
      m_clear();
      sbq.delete();
      @(posedge clk);
      #1;
      check_bubble_reset("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic st;
      int   ns;
      m_clear();
      do_reset();

      // post-reset NOP
      run_cycle(16'h0800, 16'h0002, 1'b0, 1'b0, 3'd0, 16'h0000, st);
      check_val("nop_regWrite", {31'd0, regWrite}, 32'h0);
      check_val("nop_instrOut", {16'd0, instrOut}, 32'h0000_0800);

      // seed registers through write-back
      run_cycle(16'h0800, 16'h0004, 1'b0, 1'b1, 3'd2, 16'hBEEF, st);
      run_cycle(16'h0800, 16'h0006, 1'b0, 1'b1, 3'd1, 16'h0F0F, st);

      // same-cycle write-back bypass into an R-type reading R3
      run_cycle(16'hDB04, 16'h0010, 1'b0, 1'b1, 3'd3, 16'h1234, st);
      check_val("bypass_rs", {16'd0, rsData}, 32'h0000_1234);

      // LBI, store (waits on R1 from the R-type), branch
      issue_instr(16'hC681, 16'h0012, ns);
      check_val("lbi_imm", {16'd0, immExt}, 32'h0000_FF81);
      issue_instr(16'h8150, 16'h0014, ns);
      issue_instr(16'h23FE, 16'h0016, ns);

      // RAW on R2: exactly two stall cycles
      issue_instr(16'h4045, 16'h0020, ns);
      issue_instr(16'hDA70, 16'h0022, ns);
      check_val("raw_stall_cycles", ns, 32'd2);

      // flush during stall squashes a writer of R7 without marking R7
      issue_instr(16'h40A0, 16'h0030, ns);
      run_cycle(16'hD51C, 16'h0032, 1'b0, 1'b0, 3'd0, 16'h0000, st);
      check_val("pre_flush_stall", {31'd0, st}, 32'h1);
      run_cycle(16'hD51C, 16'h0032, 1'b1, 1'b0, 3'd0, 16'h0000, st);
      issue_instr(16'hD700, 16'h0034, ns);
      check_val("flush_no_score", ns, 32'd0);

      // reset mid-stall with counter[5] freshly loaded
      issue_instr(16'h40A0, 16'h0040, ns);
      @(negedge clk);
      instruction = 16'hD500; pcIn = 16'h0042; flush = 1'b0; wbEn = 1'b0;
      #1;
      check_val("stall_cnt5", {31'd0, stall}, 32'h1);
      rst = 1'b1;
      #1;
      check_bubble_reset("midrst");
      @(posedge clk);
      #1;
      check_bubble_reset("rst_edge");
      m_clear();
      sbq.delete();
      @(negedge clk);
      rst = 1'b0; instruction = 16'h0800;
      issue_instr(16'hD500, 16'h0044, ns);
      check_val("after_rst_stall", ns, 32'd0);

      // HALT then an I-type writing R1 never issues
      issue_instr(16'h0000, 16'h0050, ns);
      check_val("halt_set", {31'd0, halt}, 32'h1);
      for (int k = 0; k < 3; k++) begin
         run_cycle(16'h403F, 16'h0052, 1'b0, 1'b0, 3'd0, 16'h0000, st);
         check_val("halt_no_write", {31'd0, regWrite}, 32'h0);
      end

      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
